// File: rtl/pc_fetch_redirect_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_redirect_pkg
// Shared definitions for the IF-stage PC generator / fetch sequencer:
//   fetch_state_e        - fetch sequencer states
//   RESET_PC_DEFAULT     - default boot PC
//   FLUSH_STAGES_DEFAULT - default number of younger pipeline registers flushed
//   INST_NOP             - canonical NOP encoding (addi x0, x0, 0)
//   word_align()         - clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package pc_fetch_redirect_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
    localparam int          FLUSH_STAGES_DEFAULT = 3;
    localparam logic [31:0] INST_NOP             = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_redirect_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_redirect_if
// Bundles the instruction-memory request/response channel and the IF/ID
// valid/ready delivery channel.
//   master : the fetch unit (drives imem_req/imem_addr, if_valid/if_pc/if_inst)
//   slave  : the environment (instruction memory + IF/ID register)
// -----------------------------------------------------------------------------
interface pc_fetch_redirect_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output if_valid, if_pc, if_inst,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  if_valid, if_pc, if_inst,
        output if_ready
    );

endinterface

// File: rtl/pc_fetch_redirect_fetch_buffer.sv
// -----------------------------------------------------------------------------
// pc_fetch_redirect_fetch_buffer
// One-entry {pc, inst} holding register between the imem response and IF/ID.
// Contents are zeroed whenever the entry is emptied so that the delivered
// pc/inst read as zero while nothing is buffered.
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : capture pc_i/inst_i and mark the entry valid
//   clear_i    : empty the entry (wins over load_i)
//   pc_i       : PC of the instruction being captured
//   inst_i     : instruction being captured
//   valid_o    : entry holds an instruction
//   pc_o       : buffered PC
//   inst_o     : buffered instruction
// -----------------------------------------------------------------------------
module pc_fetch_redirect_fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear_i) begin
            valid_d = 1'b0;
            pc_d    = '0;
            inst_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/pc_fetch_redirect.sv
// -----------------------------------------------------------------------------
// pc_fetch_redirect
// IF-stage PC generator and single-outstanding instruction-fetch sequencer.
// Fetches one word at a time, holds it for IF/ID until accepted, and reloads
// the PC on a MEM-stage redirect, flushing younger stages and discarding any
// fetch that was already in flight.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (master)    : imem request/response + IF/ID valid/ready delivery
//   redirect_valid  : MEM-stage taken branch / jump this cycle
//   redirect_target : new PC from MEM stage (low two bits ignored)
//   flush           : per-stage flush, bit0 = IF/ID (combinational)
//   misalign        : redirect target had non-zero byte offset (combinational)
//   redirect_count  : redirects taken since reset, wraps
// -----------------------------------------------------------------------------
module pc_fetch_redirect
    import pc_fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          FLUSH_STAGES = FLUSH_STAGES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    pc_fetch_redirect_if.master     bus,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_target,
    output logic [FLUSH_STAGES-1:0] flush,
    output logic                    misalign,
    output logic [31:0]             redirect_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;

    logic         buf_load, buf_clear, buf_valid;
    logic [31:0]  buf_pc, buf_inst;
    logic         req, accept, deliver;

    pc_fetch_redirect_fetch_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (pc_q),
        .inst_i  (bus.imem_rdata),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .inst_o  (buf_inst)
    );

    // A full buffer blocks new requests, keeping at most one fetch in flight.
    assign req     = (state_q == ST_FETCH) && !buf_valid;
    assign accept  = req && bus.imem_ready;
    // A redirect cancels delivery even when IF/ID is ready.
    assign deliver = (state_q == ST_HOLD) && buf_valid && bus.if_ready && !redirect_valid;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    buf_load = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (deliver) begin
                    pc_d      = pc_q + 32'd4;
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: if (bus.imem_rvalid) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase

        // Redirect overrides everything above. The in-flight response (if
        // any) must be swallowed in DRAIN; if it lands this very cycle, or
        // none was accepted, we can fetch the new target straight away.
        if (redirect_valid) begin
            pc_d      = word_align(redirect_target);
            buf_load  = 1'b0;
            buf_clear = 1'b1;
            cnt_d     = cnt_q + 32'd1;
            unique case (state_q)
                ST_FETCH: state_d = accept ? ST_DRAIN : ST_FETCH;
                ST_WAIT:  state_d = bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (state_q == ST_HOLD) && buf_valid;
    assign bus.if_pc     = buf_pc;
    assign bus.if_inst   = buf_inst;

    assign flush          = {FLUSH_STAGES{redirect_valid}};
    assign misalign       = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_redirect
// Directed bench for pc_fetch_redirect. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or 1 ns after an input change for
// the combinational flush/misalign outputs).
// -----------------------------------------------------------------------------
module tb_pc_fetch_redirect;
    import pc_fetch_redirect_pkg::*;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [2:0]  flush;
    logic        misalign;
    logic [31:0] redirect_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I0    = 32'h0010_0093;
    localparam logic [31:0] I4    = 32'h0020_0113;
    localparam logic [31:0] I8    = 32'h0030_0193;
    localparam logic [31:0] IC    = 32'h0040_0213;
    localparam logic [31:0] I100  = 32'h0050_0293;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    pc_fetch_redirect_if bus ();

    pc_fetch_redirect #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_STAGES (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush           (flush),
        .misalign        (misalign),
        .redirect_count  (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=0x%08h req=0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Wait (bounded) for a request, check its address, and let imem accept it.
    task automatic do_accept(input string tag, input logic [31:0] exp_addr);
        for (int i = 0; i < 8 && bus.imem_req !== 1'b1; i++) @(negedge clk);
        chk_eq({tag, "_req"}, 32'(bus.imem_req), 32'd1);
        chk_eq({tag, "_addr"}, bus.imem_addr, exp_addr);
        bus.imem_ready = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
    endtask

    task automatic do_resp(input logic [31:0] data);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic do_deliver(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        chk_eq({tag, "_vld"}, 32'(bus.if_valid), 32'd1);
        chk_eq({tag, "_pc"}, bus.if_pc, exp_pc);
        chk_eq({tag, "_inst"}, bus.if_inst, exp_inst);
        bus.if_ready = 1'b1;
        @(negedge clk);
        bus.if_ready = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.if_ready    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_eq("rst_req",   32'(bus.imem_req), 32'd0);
        chk_eq("rst_vld",   32'(bus.if_valid), 32'd0);
        chk_eq("rst_pc",    bus.if_pc, 32'd0);
        chk_eq("rst_inst",  bus.if_inst, 32'd0);
        chk_eq("rst_flush", 32'(flush), 32'd0);
        chk_eq("rst_mis",   32'(misalign), 32'd0);
        chk_eq("rst_cnt",   redirect_count, 32'd0);

        rst = 1'b0;
        chk_eq("boot_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk_eq("boot_fetch_req", 32'(bus.imem_req), 32'd1);

        // Sequential fetch 0x0, 0x4, 0x8
        do_accept("f0", 32'h0);
        chk_eq("f0_wait_noreq", 32'(bus.imem_req), 32'd0);
        do_resp(I0);
        do_deliver("d0", 32'h0, I0);
        do_accept("f4", 32'h4);
        do_resp(I4);
        do_deliver("d4", 32'h4, I4);
        do_accept("f8", 32'h8);
        do_resp(I8);
        chk_eq("seq_cnt", redirect_count, 32'd0);

        // Stall at 0x8 for five cycles
        for (int i = 0; i < 5; i++) begin
            chk_eq("stall_vld",  32'(bus.if_valid), 32'd1);
            chk_eq("stall_pc",   bus.if_pc, 32'h8);
            chk_eq("stall_inst", bus.if_inst, I8);
            chk_eq("stall_req",  32'(bus.imem_req), 32'd0);
            @(negedge clk);
        end
        do_deliver("d8", 32'h8, I8);
        do_accept("fC", 32'hC);
        do_resp(IC);
        do_deliver("dC", 32'hC, IC);

        // Redirect while WAIT, stale response two cycles later
        do_accept("f10", 32'h10);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        chk_eq("wr_flush", 32'(flush), 32'h7);
        chk_eq("wr_mis",   32'(misalign), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_eq("wr_flush_off", 32'(flush), 32'd0);
        chk_eq("wr_drain_req", 32'(bus.imem_req), 32'd0);
        chk_eq("wr_cnt",       redirect_count, 32'd1);
        @(negedge clk);
        do_resp(STALE);
        chk_eq("wr_stale_vld", 32'(bus.if_valid), 32'd0);
        do_accept("f100", 32'h100);
        do_resp(I100);
        do_deliver("d100", 32'h100, I100);

        // Redirect coinciding with the response: no drain cycle
        do_accept("f104", 32'h104);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = STALE;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        redirect_valid  = 1'b0;
        chk_eq("rv_req",  32'(bus.imem_req), 32'd1);
        chk_eq("rv_addr", bus.imem_addr, 32'h200);
        chk_eq("rv_vld",  32'(bus.if_valid), 32'd0);
        chk_eq("rv_cnt",  redirect_count, 32'd2);

        // Misaligned redirect while FETCH not accepted
        redirect_valid  = 1'b1;
        redirect_target = 32'h302;
        #1;
        chk_eq("mis_pulse", 32'(misalign), 32'd1);
        chk_eq("mis_flush", 32'(flush), 32'h7);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_eq("mis_off",  32'(misalign), 32'd0);
        chk_eq("mis_req",  32'(bus.imem_req), 32'd1);
        chk_eq("mis_addr", bus.imem_addr, 32'h300);
        chk_eq("mis_cnt",  redirect_count, 32'd3);

        // Redirect in HOLD with if_ready high: no handshake, no pc+4
        do_accept("f300", 32'h300);
        do_resp(INST_NOP);
        chk_eq("hold_vld", 32'(bus.if_valid), 32'd1);
        bus.if_ready    = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h400;
        @(negedge clk);
        bus.if_ready   = 1'b0;
        redirect_valid = 1'b0;
        chk_eq("hr_vld",  32'(bus.if_valid), 32'd0);
        chk_eq("hr_addr", bus.imem_addr, 32'h400);
        chk_eq("hr_cnt",  redirect_count, 32'd4);

        // Reset during WAIT, then a late response after release
        do_accept("f400", 32'h400);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("ar_req",  32'(bus.imem_req), 32'd0);
        chk_eq("ar_vld",  32'(bus.if_valid), 32'd0);
        chk_eq("ar_addr", bus.imem_addr, 32'h0);
        chk_eq("ar_cnt",  redirect_count, 32'd0);
        @(negedge clk);
        rst             = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = STALE;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk_eq("late_vld",  32'(bus.if_valid), 32'd0);
        chk_eq("late_req",  32'(bus.imem_req), 32'd1);
        chk_eq("late_addr", bus.imem_addr, 32'h0);
        do_accept("r0", 32'h0);
        do_resp(I0);
        do_deliver("rd0", 32'h0, I0);

        // Back-to-back redirects: latest target wins, both counted
        redirect_valid  = 1'b1;
        redirect_target = 32'h500;
        @(negedge clk);
        redirect_target = 32'h600;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk_eq("b2b_cnt",  redirect_count, 32'd2);
        chk_eq("b2b_req",  32'(bus.imem_req), 32'd1);
        chk_eq("b2b_addr", bus.imem_addr, 32'h600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
